// File: rtl/sextium_mem_pkg.sv
// Shared definitions for the memory port arbiter: sequencing states,
// requester indices and default bus widths.
package sextium_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-requester round-robin pick with loader burst lock.
// Purely combinational; the caller registers the decision.
module mem_rr_pick
  import sextium_mem_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic last_grant,
  input  logic lock_held,
  output logic grant_valid,
  output logic grant_sel
);

  // Lock restricts the grant to the loader; otherwise the requester that
  // was not served last wins a tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = REQ_CPU;
    if (lock_held) begin
      grant_valid = l_req;
      grant_sel   = REQ_LDR;
    end else if (c_req && l_req) begin
      grant_valid = 1'b1;
      grant_sel   = (last_grant == REQ_CPU) ? REQ_LDR : REQ_CPU;
    end else if (c_req) begin
      grant_valid = 1'b1;
      grant_sel   = REQ_CPU;
    end else if (l_req) begin
      grant_valid = 1'b1;
      grant_sel   = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the CPU controller and the
// loader/IO port. One access at a time: IDLE -> ACCESS -> (WAIT) -> RESP.
// The request is latched straight into the memory-side output registers
// at grant time, so later changes on the requester inputs are ignored.
module mem_port_arbiter
  import sextium_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: RD_LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

  mem_state_t state_reg, state_next;
  logic       sel_reg;
  logic       last_grant_reg;
  logic       lock_held_reg;
  logic [3:0] cnt_reg;
  logic       grant_valid;
  logic       grant_sel;

  mem_rr_pick u_pick (
    .c_req       (c_req),
    .l_req       (l_req),
    .last_grant  (last_grant_reg),
    .lock_held   (lock_held_reg),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: writes skip WAIT, reads sit in WAIT until the counter expires.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = m_we ? RESP : WAIT;
      WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latching, memory strobe, latency count, read capture, ack pulses
  // and lock bookkeeping; strobes and acks are registered one-cycle pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_reg        <= REQ_CPU;
      last_grant_reg <= REQ_LDR;
      lock_held_reg  <= 1'b0;
      cnt_reg        <= 4'd0;
      m_en           <= 1'b0;
      m_we           <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      c_ack          <= 1'b0;
      l_ack          <= 1'b0;
      c_rdata        <= '0;
      l_rdata        <= '0;
    end else begin
      m_en  <= 1'b0;
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          // A held lock is dropped as soon as the loader releases l_lock.
          if (lock_held_reg && !l_lock) lock_held_reg <= 1'b0;
          if (grant_valid) begin
            sel_reg        <= grant_sel;
            last_grant_reg <= grant_sel;
            m_en           <= 1'b1;
            m_we           <= (grant_sel == REQ_LDR) ? l_we    : c_we;
            m_addr         <= (grant_sel == REQ_LDR) ? l_addr  : c_addr;
            m_wdata        <= (grant_sel == REQ_LDR) ? l_wdata : c_wdata;
          end
        end
        ACCESS: begin
          if (m_we) begin
            c_ack <= (sel_reg == REQ_CPU);
            l_ack <= (sel_reg == REQ_LDR);
          end else begin
            cnt_reg <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (sel_reg == REQ_LDR) l_rdata <= m_rdata;
            else                    c_rdata <= m_rdata;
            c_ack <= (sel_reg == REQ_CPU);
            l_ack <= (sel_reg == REQ_LDR);
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          lock_held_reg <= (sel_reg == REQ_LDR) ? l_lock : 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-1 instance exercises
// arbitration, lock and reset; a latency-3 instance checks read timing.
// Expected acks are queued when a request is raised and matched on the ack.
module tb_mem_port_arbiter;

  typedef struct {
    logic        port;   // 0 = CPU, 1 = loader
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  // Latency-1 instance signals
  logic        c_req, c_we, c_ack, l_req, l_we, l_lock, l_ack;
  logic [15:0] c_addr, c_wdata, c_rdata, l_addr, l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic [15:0] mem1 [0:65535];

  // Latency-3 instance signals
  logic        c3_req, c3_ack, l3_ack, m3_en, m3_we;
  logic [15:0] c3_addr, c3_rdata, l3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic [15:0] mem3 [0:65535];
  logic [15:0] p3_0, p3_1, p3_2;
  logic        zero1;
  logic [15:0] zero16;

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LATENCY(1)) dut (
    .clock(clk), .reset(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_ack(l_ack), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LATENCY(3)) dut3 (
    .clock(clk), .reset(rst_n),
    .c_req(c3_req), .c_we(zero1), .c_addr(c3_addr), .c_wdata(zero16),
    .c_ack(c3_ack), .c_rdata(c3_rdata),
    .l_req(zero1), .l_we(zero1), .l_addr(zero16), .l_wdata(zero16),
    .l_lock(zero1), .l_ack(l3_ack), .l_rdata(l3_rdata),
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata),
    .m_rdata(m3_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: read data is poisoned outside the valid window so a
  // capture on the wrong cycle shows up as wrong data.
  always @(posedge clk) begin
    if (m_en && m_we) mem1[m_addr] = m_wdata;
    if (m_en && !m_we) m_rdata <= mem1[m_addr];
    else               m_rdata <= 16'hDEAD;
  end

  always @(posedge clk) begin
    if (m3_en && m3_we) mem3[m3_addr] = m3_wdata;
    if (m3_en && !m3_we) p3_0 <= mem3[m3_addr];
    else                 p3_0 <= 16'hDEAD;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign m3_rdata = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack on the latency-1 instance must match the oldest
  // queued expectation in port and, for reads, data.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (c_ack || l_ack)) begin
      check("ack_exclusive", {31'b0, c_ack & l_ack}, 32'd0);
      check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_ack_port", {31'b0, l_ack}, {31'b0, e.port});
        if (e.rd) check("sb_rdata", l_ack ? {16'b0, l_rdata} : {16'b0, c_rdata}, {16'b0, e.data});
        $display("ack port=%0d rd=%0d data=0x%04h", l_ack, e.rd, l_ack ? l_rdata : c_rdata);
      end
    end
  end

  // Serve whatever is currently requested; each requester drops its request
  // in the cycle after its ack. Cycle 0 is the cycle the request was raised.
  task automatic serve(input int budget, output int c_at, output int l_at,
                       output int en_at, output int en_cnt,
                       output logic [15:0] en_addr, output logic en_we);
    bit cs, ls;
    c_at = -1; l_at = -1; en_at = -1; en_cnt = 0; en_addr = '0; en_we = 1'b0;
    for (int i = 0; i < budget && (c_req || l_req); i++) begin
      @(negedge clk);
      cs = c_ack;
      ls = l_ack;
      if (cs) c_at = i;
      if (ls) l_at = i;
      if (m_en) begin
        en_cnt++;
        if (en_at < 0) begin
          en_at = i; en_addr = m_addr; en_we = m_we;
        end
      end
      @(posedge clk); #1;
      if (cs) c_req = 1'b0;
      if (ls) l_req = 1'b0;
    end
    check("serve_timeout", {30'b0, c_req, l_req}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_at, l_at, en_at, en_cnt, n, cpu_after, ens, ack3;
    logic [15:0] en_addr;
    logic en_we;
    bit cs, ls;

    rst_n = 1'b0; zero1 = 1'b0; zero16 = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
    c3_req = 0; c3_addr = '0;
    mem1[16'h0010] = 16'hBEEF;
    mem1[16'h0030] = 16'h1111; mem1[16'h0031] = 16'h2222;
    mem1[16'h0032] = 16'h3333; mem1[16'h0033] = 16'h4444;
    mem1[16'h0040] = 16'h4040; mem1[16'h0050] = 16'h5050;
    mem3[16'h0005] = 16'h00FF;

    // Reset state
    @(negedge clk);
    check("rst_m_en", {31'b0, m_en}, 0);
    check("rst_m_we", {31'b0, m_we}, 0);
    check("rst_m_addr", {16'b0, m_addr}, 0);
    check("rst_m_wdata", {16'b0, m_wdata}, 0);
    check("rst_acks", {30'b0, c_ack, l_ack}, 0);
    check("rst_rdata", {c_rdata, l_rdata}, 0);
    check("rst_m3_en", {31'b0, m3_en}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU read, latency 1: m_en at T+1, ack at T+3, data held afterwards
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    sb.push_back('{1'b0, 1'b1, 16'hBEEF});
    serve(20, c_at, l_at, en_at, en_cnt, en_addr, en_we);
    $display("cpu read 0x0010: ack@%0d en@%0d", c_at, en_at);
    check("t1_ack_cycle", c_at, 3);
    check("t1_en_cycle", en_at, 1);
    check("t1_en_count", en_cnt, 1);
    check("t1_m_addr", {16'b0, en_addr}, 32'h10);
    check("t1_no_lack", l_at, -1);
    @(negedge clk);
    check("t1_rdata_hold", {16'b0, c_rdata}, 32'hBEEF);

    // Loader write: m_en/m_we at T+1 only, ack at T+2, CPU untouched
    @(posedge clk); #1;
    l_req = 1; l_we = 1; l_addr = 16'h0020; l_wdata = 16'h1234;
    sb.push_back('{1'b1, 1'b0, 16'h0000});
    serve(20, c_at, l_at, en_at, en_cnt, en_addr, en_we);
    $display("ldr write 0x0020: ack@%0d en@%0d", l_at, en_at);
    check("t2_ack_cycle", l_at, 2);
    check("t2_en_cycle", en_at, 1);
    check("t2_en_we", {31'b0, en_we}, 1);
    check("t2_en_count", en_cnt, 1);
    check("t2_no_cack", c_at, -1);
    check("t2_mem", {16'b0, mem1[16'h0020]}, 32'h1234);
    l_we = 0;

    // Simultaneous reads, two rounds: CPU, loader, CPU, loader
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      c_req = 1; c_addr = 16'h0030 + 16'(2 * r);
      l_req = 1; l_addr = 16'h0031 + 16'(2 * r);
      sb.push_back('{1'b0, 1'b1, mem1[16'h0030 + 16'(2 * r)]});
      sb.push_back('{1'b1, 1'b1, mem1[16'h0031 + 16'(2 * r)]});
      serve(40, c_at, l_at, en_at, en_cnt, en_addr, en_we);
      $display("rr round %0d: cpu ack@%0d ldr ack@%0d", r, c_at, l_at);
      check("rr_cpu_ack", c_at, 3);
      check("rr_ldr_ack", l_at, 7);
      check("rr_en_count", en_cnt, 2);
    end
    @(negedge clk);
    check("rr_l_rdata_hold", {16'b0, l_rdata}, 32'h4444);

    // Loader burst under lock while CPU waits
    @(posedge clk); #1;
    l_req = 1; l_we = 1; l_addr = 16'h0100; l_wdata = 16'hA000; l_lock = 1;
    sb.push_back('{1'b1, 1'b0, 16'h0000});
    sb.push_back('{1'b1, 1'b0, 16'h0000});
    sb.push_back('{1'b1, 1'b0, 16'h0000});
    sb.push_back('{1'b0, 1'b1, 16'h4040});
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 16'h0040;
    n = 0; cpu_after = -1;
    for (int i = 0; i < 80 && c_req; i++) begin
      @(negedge clk);
      cs = c_ack; ls = l_ack;
      if (cs) cpu_after = n;
      @(posedge clk); #1;
      if (ls) begin
        n++;
        if (n < 3) begin
          l_addr = 16'h0100 + 16'(n); l_wdata = 16'hA000 + 16'(n); l_lock = (n < 2);
        end else begin
          l_req = 0; l_we = 0; l_lock = 0;
        end
      end
      if (cs) c_req = 0;
    end
    $display("lock burst: loader writes=%0d before cpu grant=%0d", n, cpu_after);
    check("lock_cpu_after_n", cpu_after, 3);
    check("lock_timeout", {31'b0, c_req}, 0);
    check("lock_mem0", {16'b0, mem1[16'h0100]}, 32'hA000);
    check("lock_mem2", {16'b0, mem1[16'h0102]}, 32'hA002);

    // Reset during WAIT of a CPU read, then normal service
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 16'h0050;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_m_en", {31'b0, m_en}, 0);
    check("arst_m_addr", {16'b0, m_addr}, 0);
    check("arst_c_rdata", {16'b0, c_rdata}, 0);
    @(negedge clk);
    check("arst_no_cack", {31'b0, c_ack}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{1'b0, 1'b1, 16'h5050});
    serve(20, c_at, l_at, en_at, en_cnt, en_addr, en_we);
    $display("post-reset cpu read 0x0050: ack@%0d", c_at);
    check("arst_ack_cycle", c_at, 3);
    check("arst_en_addr", {16'b0, en_addr}, 32'h50);

    // Latency-3 instance: CPU read, ack at T+5, single strobe
    @(posedge clk); #1;
    c3_req = 1; c3_addr = 16'h0005;
    ens = 0; ack3 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m3_en) ens++;
      if (c3_ack && ack3 < 0) ack3 = i;
      @(posedge clk); #1;
      if (ack3 >= 0) c3_req = 0;
    end
    $display("lat3 cpu read 0x0005: ack@%0d strobes=%0d data=0x%04h", ack3, ens, c3_rdata);
    check("lat3_ack_cycle", ack3, 5);
    check("lat3_en_count", ens, 1);
    check("lat3_rdata", {16'b0, c3_rdata}, 32'h00FF);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
